// File: rtl/alu_share_arb_if.sv
// Bundle of requester, response, alu and status signals around alu_share_arb.
// The arbiter takes the slave modport; the requester/alu environment takes master.
interface alu_share_arb_if #(
    parameter int NREQ   = 2,
    parameter int DATA_W = 32,
    parameter int OP_W   = 12
);
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*OP_W-1:0]   req_op;
    logic [NREQ*DATA_W-1:0] req_src1;
    logic [NREQ*DATA_W-1:0] req_src2;
    logic [NREQ-1:0]        rsp_valid;
    logic [NREQ-1:0]        rsp_ready;
    logic [DATA_W-1:0]      rsp_result;
    logic                   rsp_err;
    logic [OP_W-1:0]        alu_op;
    logic [DATA_W-1:0]      alu_src1;
    logic [DATA_W-1:0]      alu_src2;
    logic [DATA_W-1:0]      alu_result;
    logic [31:0]            done_cnt;

    modport slave (
        input  req_valid, req_op, req_src1, req_src2, rsp_ready, alu_result,
        output req_ready, rsp_valid, rsp_result, rsp_err,
               alu_op, alu_src1, alu_src2, done_cnt
    );

    modport master (
        output req_valid, req_op, req_src1, req_src2, rsp_ready, alu_result,
        input  req_ready, rsp_valid, rsp_result, rsp_err,
               alu_op, alu_src1, alu_src2, done_cnt
    );
endinterface

// File: rtl/alu_share_arb.sv
// Round-robin sharing of one combinational alu among NREQ requesters:
// IDLE grants and latches, EXEC drives the alu, RESP holds the result until consumed.
module alu_share_arb #(
    parameter int NREQ   = 2,
    parameter int DATA_W = 32,
    parameter int OP_W   = 12
) (
    input  logic             clk,
    input  logic             resetn,
    alu_share_arb_if.slave   bus
);
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   rr_q, gnt_q, gnt_idx;
    logic [OP_W-1:0]    op_q;
    logic [DATA_W-1:0]  src1_q, src2_q, result_q;
    logic               err_q;
    logic [31:0]        done_q;
    logic               any_valid;
    logic               op_legal;
    int                 cand;

    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    rsp_valid;
    logic [DATA_W-1:0]  rsp_result;
    logic               rsp_err;
    logic [OP_W-1:0]    alu_op;
    logic [DATA_W-1:0]  alu_src1, alu_src2;

    // First valid requester at offsets rr+1 .. rr+NREQ; the first hit sticks.
    always_comb begin
        gnt_idx   = rr_q;
        any_valid = 1'b0;
        cand      = 0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(rr_q) + k) % NREQ;
            if (!any_valid && bus.req_valid[cand]) begin
                any_valid = 1'b1;
                gnt_idx   = IDX_W'(cand);
            end
        end
    end

    assign op_legal = $onehot(op_q);

    always_comb begin
        state_d    = state_q;
        req_ready  = '0;
        rsp_valid  = '0;
        rsp_result = '0;
        rsp_err    = 1'b0;
        alu_op     = '0;
        alu_src1   = '0;
        alu_src2   = '0;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    // Reset holds the FSM in IDLE, so gate the grant to keep outputs at 0.
                    req_ready[gnt_idx] = resetn;
                    state_d            = EXEC;
                end
            end
            EXEC: begin
                if (op_legal) begin
                    alu_op   = op_q;
                    alu_src1 = src1_q;
                    alu_src2 = src2_q;
                end
                state_d = RESP;
            end
            RESP: begin
                rsp_valid[gnt_q] = 1'b1;
                rsp_result       = result_q;
                rsp_err          = err_q;
                if (bus.rsp_ready[gnt_q]) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            rr_q     <= IDX_W'(NREQ - 1);
            gnt_q    <= '0;
            op_q     <= '0;
            src1_q   <= '0;
            src2_q   <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            done_q   <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (any_valid) begin
                        gnt_q  <= gnt_idx;
                        rr_q   <= gnt_idx;
                        op_q   <= bus.req_op[int'(gnt_idx)*OP_W +: OP_W];
                        src1_q <= bus.req_src1[int'(gnt_idx)*DATA_W +: DATA_W];
                        src2_q <= bus.req_src2[int'(gnt_idx)*DATA_W +: DATA_W];
                    end
                end
                EXEC: begin
                    result_q <= op_legal ? bus.alu_result : '0;
                    err_q    <= !op_legal;
                end
                RESP: begin
                    if (bus.rsp_ready[gnt_q]) done_q <= done_q + 32'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready  = req_ready;
    assign bus.rsp_valid  = rsp_valid;
    assign bus.rsp_result = rsp_result;
    assign bus.rsp_err    = rsp_err;
    assign bus.alu_op     = alu_op;
    assign bus.alu_src1   = alu_src1;
    assign bus.alu_src2   = alu_src2;
    assign bus.done_cnt   = done_q;
endmodule
